modexp_ctrl: RTL and testbench
==============================

# modexp_ctrl

Sequencer for the RSA modular exponentiation `result = base^exponent mod modulus` using left-to-right binary square-and-multiply. It issues every square and multiply to the shared shift-add modular multiplier through that multiplier's `ds`/`ready` handshake. It holds the accumulator and exponent state and exposes a start/busy/done interface to the RSA top level. The multiplier is instantiated beside this block, not inside it.

## Interface
- `WIDTH`, 1024: operand width. Must equal the multiplier operand width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset. Shared with the multiplier.
- `start` in 1: request. Sampled only in IDLE.
- `base` in WIDTH: operand. Precondition: `base < modulus`.
- `exponent` in WIDTH: exponent.
- `modulus` in WIDTH: modulus. Precondition: `modulus >= 2`.
- `busy` out 1: high from the cycle after `start` is accepted until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse when `result` becomes valid.
- `result` out WIDTH: final value. Held until the next accepted `start`.
- `mm_ds` out 1: multiplier start pulse, one cycle wide.
- `mm_mpand` out WIDTH: multiplier multiplicand.
- `mm_mplier` out WIDTH: multiplier multiplier.
- `mm_modulus` out WIDTH: multiplier modulus.
- `mm_ready` in 1: multiplier idle/result-valid flag.
- `mm_product` in WIDTH: multiplier result.

## Operation
- **Reset:** state IDLE. `busy`, `done`, `mm_ds` = 0. `result`, `acc`, `mm_*` operand registers = 0.
- **IDLE:** on `start` = 1:
  - latch `base`, `exponent`, `modulus`;
  - `bitcnt <= WIDTH`;
  - go to SCAN.
  - While not in IDLE, `start` is ignored.
- **SCAN:** one exponent bit per cycle, MSB first. Shift the latched exponent left and decrement `bitcnt`.
  - On the first 1 bit: `acc <= base`, consume the bit, go to NEXT.
  - If `bitcnt` reaches 0 with no 1 found (exponent = 0): `acc <= 1`, go to FIN.
- **NEXT:**
  - If `bitcnt` = 0, go to FIN.
  - Otherwise go to SQ_ISSUE with `mm_mpand = mm_mplier = acc`.
- **x_ISSUE** (x = SQ or MUL): wait for `mm_ready` = 1, then pulse `mm_ds` = 1 for exactly one cycle and go to x_ACK.
- **x_ACK:** wait for `mm_ready` = 0. This step is mandatory because `ready` is already high before the multiplier starts.
- **x_RUN:** on the first cycle with `mm_ready` = 1, `acc <= mm_product`.
  - SQ_RUN:
    - if the current exponent bit = 1, go to MUL_ISSUE with `mm_mpand = acc_new`, `mm_mplier = base`;
    - otherwise shift the exponent, decrement `bitcnt`, go to NEXT.
  - MUL_RUN: shift the exponent, decrement `bitcnt`, go to NEXT.
- **Operand stability:** `mm_mpand`, `mm_mplier`, `mm_modulus` are held stable from ISSUE through the RUN capture.
- **FIN:** `result <= acc`, `done` = 1 for one cycle, go to IDLE.
- **Multiplier result window:** `mm_product` is valid only while `mm_ready` = 1 after completion. It is captured in that first cycle, never later.
- **Precondition violations** (`base >= modulus`, `modulus < 2`): `result` is undefined, but the FSM must still terminate with `done`.
- **Exponent = 1:** result = base, zero multiplier requests.
- **Widths:** `bitcnt` is clog2(WIDTH+1) bits. No arithmetic is performed in this block.

## Timing
- Start accepted at edge t0. `busy` = 1 from t0+1.
- SCAN takes `WIDTH - k + 1` cycles, where k = bit length of the exponent. For exponent = 0 it takes WIDTH cycles.
- Each multiplier request takes 1 cycle (ISSUE) + `bitlen(mm_mplier) + 1` cycles (multiplier busy) + 1 capture cycle. Latency is data-dependent, and the controller never assumes a fixed multiplier latency.
- Request count is (k-1) squares + (popcount(exponent) - 1) multiplies.
- `done` pulse and `result` update occur on the same edge. `busy` drops the cycle after `done`.
- A `start` present on the `done` cycle is not accepted. It is accepted on the next cycle in IDLE.
- `rst_n` asserted mid-operation: all state returns to reset values immediately. No `done` is generated, and the multiplier is reset by the same `rst_n`.

## Structure
- **Shared package `rsa_pkg`:**
  - `RSA_WIDTH` = 1024;
  - state enum `modexp_state_t` (IDLE, SCAN, NEXT, SQ_ISSUE, SQ_ACK, SQ_RUN, MUL_ISSUE, MUL_ACK, MUL_RUN, FIN).
- **Sub-module `mm_req_agent`:** the ISSUE/ACK/RUN handshake. Inputs `req`, `mm_ready`; outputs `mm_ds`, `cap`. It is reused by future controllers that share the multiplier.

## Test plan
- base=4, exponent=13, modulus=497 → result=445. Exactly 5 `mm_ds` pulses (3 squares, 2 multiplies), `done` exactly once.
- base=2, exponent=10, modulus=1000 → result=24. `mm_ds` count = 4.
- exponent=0, base=5, modulus=7 → result=1. No `mm_ds`. `done` at t0 + WIDTH + 2.
- base=7, exponent=1, modulus=11 → result=7. No `mm_ds`. `start` pulsed repeatedly while `busy` has no effect.
- exponent=2^(WIDTH-1), base=3, modulus=2^(WIDTH-1)+1 → 1023 squares, 0 multiplies. `mm_ds` never asserted while `mm_ready` = 0.
- Assert `rst_n` = 0 during SQ_RUN, then release → `busy`, `done`, `mm_ds`, `result` all 0. A new run (4, 13, 497) returns 445.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared RSA types: operand width and sequencer/agent state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rsa_pkg;

    localparam int RSA_WIDTH = 1024;

    typedef enum logic [3:0] {
        IDLE,
        SCAN,
        NEXT,
        SQ_ISSUE,
        SQ_ACK,
        SQ_RUN,
        MUL_ISSUE,
        MUL_ACK,
        MUL_RUN,
        FIN
    } modexp_state_t;

    typedef enum logic [1:0] {
        AG_IDLE,
        AG_ACK,
        AG_RUN
    } mm_agent_state_t;

endpackage

// File: rtl/mm_req_agent.sv
// Issues one request to the shared modular multiplier and flags its result.
// Latency: mm_ds one cycle after req sees mm_ready; cap same cycle ready returns.
// Backpressure: holds off while mm_ready is low; never pulses mm_ds into a busy multiplier.
module mm_req_agent
    import rsa_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic mm_ready,
    output logic mm_ds,
    output logic cap
);

    mm_agent_state_t ag_state;

    // ready is already high before the multiplier starts, so the product is
    // only trusted after ready has been seen low once (AG_ACK -> AG_RUN).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ag_state <= AG_IDLE;
            mm_ds    <= 1'b0;
        end else begin
            mm_ds <= 1'b0;
            case (ag_state)
                AG_IDLE: begin
                    if (req && mm_ready) begin
                        mm_ds    <= 1'b1;
                        ag_state <= AG_ACK;
                    end
                end
                AG_ACK: begin
                    if (!mm_ready) ag_state <= AG_RUN;
                end
                AG_RUN: begin
                    if (mm_ready) ag_state <= AG_IDLE;
                end
                default: ag_state <= AG_IDLE;
            endcase
        end
    end

    // Product is captured in the very first ready cycle after completion.
    assign cap = (ag_state == AG_RUN) && mm_ready;

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external modular multiplier.
// Latency: data dependent; scan of leading zeros plus one handshake per square/multiply.
// Backpressure: waits on mm_ready for every request; start ignored unless idle.
module modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             mm_ds,
    output logic [WIDTH-1:0] mm_mpand,
    output logic [WIDTH-1:0] mm_mplier,
    output logic [WIDTH-1:0] mm_modulus,
    input  logic             mm_ready,
    input  logic [WIDTH-1:0] mm_product
);

    localparam int CW = $clog2(WIDTH + 1);

    modexp_state_t    state;
    logic [WIDTH-1:0] base_r;
    logic [WIDTH-1:0] exp_r;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    bitcnt;
    logic             req;
    logic             cap;
    logic             exp_msb;

    assign req     = (state == SQ_ISSUE) || (state == MUL_ISSUE);
    assign exp_msb = exp_r[WIDTH-1];

    mm_req_agent u_agent (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .mm_ready (mm_ready),
        .mm_ds    (mm_ds),
        .cap      (cap)
    );

    // Main sequencer: exponent is consumed MSB first by shifting it left;
    // the bit under test is always exp_r[WIDTH-1].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            base_r     <= '0;
            exp_r      <= '0;
            acc        <= '0;
            bitcnt     <= '0;
            mm_mpand   <= '0;
            mm_mplier  <= '0;
            mm_modulus <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // done is high in the first idle cycle; a start there waits one more cycle.
                    if (start && !done) begin
                        base_r     <= base;
                        exp_r      <= exponent;
                        mm_modulus <= modulus;
                        bitcnt     <= CW'(WIDTH);
                        busy       <= 1'b1;
                        state      <= SCAN;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SCAN: begin
                    exp_r  <= exp_r << 1;
                    bitcnt <= bitcnt - CW'(1);
                    if (exp_msb) begin
                        acc   <= base_r;
                        state <= NEXT;
                    end else if (bitcnt == CW'(1)) begin
                        acc   <= WIDTH'(1);
                        state <= FIN;
                    end
                end
                NEXT: begin
                    if (bitcnt == '0) begin
                        state <= FIN;
                    end else begin
                        mm_mpand  <= acc;
                        mm_mplier <= acc;
                        state     <= SQ_ISSUE;
                    end
                end
                SQ_ISSUE:  if (mm_ready)  state <= SQ_ACK;
                SQ_ACK:    if (!mm_ready) state <= SQ_RUN;
                SQ_RUN: begin
                    if (cap) begin
                        acc <= mm_product;
                        if (exp_msb) begin
                            mm_mpand  <= mm_product;
                            mm_mplier <= base_r;
                            state     <= MUL_ISSUE;
                        end else begin
                            exp_r  <= exp_r << 1;
                            bitcnt <= bitcnt - CW'(1);
                            state  <= NEXT;
                        end
                    end
                end
                MUL_ISSUE: if (mm_ready)  state <= MUL_ACK;
                MUL_ACK:   if (!mm_ready) state <= MUL_RUN;
                MUL_RUN: begin
                    if (cap) begin
                        acc    <= mm_product;
                        exp_r  <= exp_r << 1;
                        bitcnt <= bitcnt - CW'(1);
                        state  <= NEXT;
                    end
                end
                FIN: begin
                    result <= acc;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl with a behavioural shift-add multiplier model.
// Latency: multiplier model busy for bitlen(mplier)+1 cycles per request.
// Backpressure: model holds ready low while computing; controller must wait.
module tb_modexp_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] base = '0;
    logic [W-1:0] exponent = '0;
    logic [W-1:0] modulus = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         mm_ds;
    logic [W-1:0] mm_mpand;
    logic [W-1:0] mm_mplier;
    logic [W-1:0] mm_modulus;
    logic         mm_ready;
    logic [W-1:0] mm_product;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ds_cnt  = 0;
    int done_cnt = 0;
    int viol    = 0;

    logic [W-1:0] la, lb, lm;
    int           lat;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    modexp_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base       (base),
        .exponent   (exponent),
        .modulus    (modulus),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .mm_ds      (mm_ds),
        .mm_mpand   (mm_mpand),
        .mm_mplier  (mm_mplier),
        .mm_modulus (mm_modulus),
        .mm_ready   (mm_ready),
        .mm_product (mm_product)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bitlen(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    function automatic longint ref_modexp(input longint b, input longint e, input longint m);
        longint r = 1;
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % m;
            if (e[i]) r = (r * b) % m;
        end
        return r;
    endfunction

    // Multiplier model: ready high when idle; a ds pulse starts a job that
    // keeps ready low for bitlen(mplier)+1 cycles, then presents the product.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_ready   <= 1'b1;
            mm_product <= '0;
            lat        <= 0;
        end else if (mm_ready && mm_ds) begin
            mm_ready <= 1'b0;
            la       <= mm_mpand;
            lb       <= mm_mplier;
            lm       <= mm_modulus;
            lat      <= bitlen(mm_mplier) + 1;
        end else if (!mm_ready) begin
            if (lat <= 1) begin
                mm_ready   <= 1'b1;
                mm_product <= W'((longint'(la) * longint'(lb)) % longint'(lm));
            end else begin
                lat <= lat - 1;
            end
        end
    end

    // Handshake monitor: count requests/done pulses, flag ds into a busy multiplier,
    // and confirm operands stay put while a job is in flight.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mm_ds) ds_cnt++;
            if (mm_ds && !mm_ready) viol++;
            if (done) done_cnt++;
            if (!mm_ready)
                check("opnd_stable", {16'h0, mm_mpand, mm_mplier, mm_modulus}, {16'h0, la, lb, lm});
        end
    end

    task automatic run(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                       input bit poke, input string tag);
        int t0;
        int k;
        int reqs;
        bit seen;
        logic [W-1:0] exp_res;
        seen    = 1'b0;
        k       = bitlen(e);
        reqs    = (k == 0) ? 0 : (k - 1) + ($countones(e) - 1);
        exp_res = W'(ref_modexp(longint'(b), longint'(e), longint'(m)));
        @(negedge clk);
        base = b; exponent = e; modulus = m; start = 1'b1;
        ds_cnt = 0; done_cnt = 0; viol = 0;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0;
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (poke) begin
                start    = 1'($urandom);
                base     = W'($urandom);
                exponent = W'($urandom);
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (e == '0) check({tag, "_latency"}, 64'(cyc - t0), 64'(W + 1));
        check({tag, "_result"}, 64'(result), 64'(exp_res));
        check({tag, "_busy_on_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_done_pulse"}, 64'({done, 31'(done_cnt)}), 64'({1'b0, 31'd1}));
        check({tag, "_ds_count"}, 64'(ds_cnt), 64'(reqs));
        check({tag, "_ds_while_busy"}, 64'(viol), 64'd0);
    endtask

    initial begin
        logic [W-1:0] rb, re, rm;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({busy, done, mm_ds}), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_operands", {16'h0, mm_mpand, mm_mplier, mm_modulus}, 64'd0);
        rst_n = 1'b1;

        run(16'd4, 16'd13, 16'd497, 1'b0, "b4e13");
        run(16'd2, 16'd10, 16'd1000, 1'b0, "b2e10");
        run(16'd5, 16'd0, 16'd7, 1'b0, "exp0");
        run(16'd7, 16'd1, 16'd11, 1'b1, "exp1_poke");
        run(16'd3, 16'h8000, 16'h8001, 1'b0, "msb_only");

        for (int n = 0; n < 8; n++) begin
            rm = W'($urandom_range(65535, 2));
            rb = W'($urandom_range(32'(rm) - 1, 0));
            re = W'($urandom_range(65535, 0));
            run(rb, re, rm, 1'(n % 2), $sformatf("rand%0d", n));
        end

        // Reset while a square is in flight, then confirm a clean restart.
        @(negedge clk);
        base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && !mm_ds; i++) @(negedge clk);
        check("rstmid_ds_seen", 64'(mm_ds), 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_mult_busy", 64'(mm_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rstmid_ctrl", 64'({busy, done, mm_ds}), 64'd0);
        check("rstmid_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(16'd4, 16'd13, 16'd497, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
